// File: rtl/alu8b_pkg.sv
// alu8b_pkg: shared opcode encoding and datapath width for the 8-bit ALU.
package alu8b_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MOD = 3'b100
    } opcode_e;
endpackage

// File: rtl/alu8b_mod.sv
// alu8b_mod: combinational 8-bit unsigned restoring remainder with divide-by-zero flag.
module alu8b_mod
    import alu8b_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_dbz
);
    logic [DATA_W:0]   w_part;
    logic [DATA_W-1:0] w_rem;
    // Shift in one dividend bit per step; the partial remainder always stays below i_b.
    always_comb begin
        w_part = '0;
        w_rem  = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_part = {w_rem, i_a[i]};
            w_rem  = (w_part >= {1'b0, i_b}) ? w_part[DATA_W-1:0] - i_b : w_part[DATA_W-1:0];
        end
    end
    assign o_dbz = (i_b == '0);
    assign o_rem = o_dbz ? '0 : w_rem;
endmodule

// File: rtl/alu8b.sv
// alu8b: 8-bit registered ALU (ADD/SUB/AND/OR/MOD), one-cycle latency, async active-high reset.
module alu8b
    import alu8b_pkg::*;
(
    input  logic              Clk_in,
    input  logic              Rst_in,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic              C_in,
    input  logic [2:0]        Opcode_in,
    output logic [DATA_W-1:0] Result_out,
    output logic              C_out
);
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_rem;
    logic              w_dbz;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic [DATA_W-1:0] r_res;
    logic              r_c;

    alu8b_mod u_mod (
        .i_a   (A_in),
        .i_b   (B_in),
        .o_rem (w_rem),
        .o_dbz (w_dbz)
    );

    assign w_sum  = {1'b0, A_in} + {1'b0, B_in} + {{DATA_W{1'b0}}, C_in};
    assign w_diff = {1'b0, A_in} - {1'b0, B_in};

    // Bit 8 of the 9-bit difference is the borrow (A < B).
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        case (Opcode_in)
            OP_ADD: {w_c, w_res} = w_sum;
            OP_SUB: {w_c, w_res} = w_diff;
            OP_AND: w_res = A_in & B_in;
            OP_OR:  w_res = A_in | B_in;
            OP_MOD: {w_c, w_res} = {w_dbz, w_rem};
            default: {w_c, w_res} = '0;
        endcase
    end

    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            r_res <= '0;
            r_c   <= 1'b0;
        end else begin
            r_res <= w_res;
            r_c   <= w_c;
        end
    end

    assign Result_out = r_res;
    assign C_out      = r_c;
endmodule

// File: tb/tb_alu8b.sv
// tb_alu8b: directed-vector self-checking bench for alu8b.
module tb_alu8b;
    import alu8b_pkg::*;

    logic       Clk_in;
    logic       Rst_in;
    logic [7:0] A_in;
    logic [7:0] B_in;
    logic       C_in;
    logic [2:0] Opcode_in;
    logic [7:0] Result_out;
    logic       C_out;

    int errs   = 0;
    int checks = 0;

    // Each row: opcode, A, B, Cin, expected {C_out, Result_out}.
    localparam int N = 22;
    logic [28:0] tab [N] = '{
        {3'b000, 8'hAA, 8'h02, 1'b0, 9'h0AC},
        {3'b000, 8'hFE, 8'h01, 1'b1, 9'h100},
        {3'b000, 8'hFF, 8'hFF, 1'b1, 9'h1FF},
        {3'b000, 8'h12, 8'h34, 1'b1, 9'h047},
        {3'b001, 8'hFF, 8'h01, 1'b1, 9'h0FE},
        {3'b001, 8'h00, 8'h01, 1'b0, 9'h1FF},
        {3'b001, 8'h05, 8'h05, 1'b1, 9'h000},
        {3'b001, 8'h10, 8'h20, 1'b1, 9'h1F0},
        {3'b010, 8'hAA, 8'h55, 1'b1, 9'h000},
        {3'b010, 8'hF0, 8'h3C, 1'b0, 9'h030},
        {3'b011, 8'hAA, 8'h55, 1'b0, 9'h0FF},
        {3'b011, 8'h0F, 8'h30, 1'b1, 9'h03F},
        {3'b100, 8'h0A, 8'h03, 1'b0, 9'h001},
        {3'b100, 8'h0A, 8'h00, 1'b1, 9'h100},
        {3'b100, 8'h05, 8'h09, 1'b0, 9'h005},
        {3'b100, 8'hC8, 8'h01, 1'b0, 9'h000},
        {3'b100, 8'hFF, 8'h10, 1'b1, 9'h00F},
        {3'b100, 8'hC8, 8'h0D, 1'b0, 9'h005},
        {3'b100, 8'hFF, 8'hFF, 1'b0, 9'h000},
        {3'b101, 8'h0A, 8'h03, 1'b1, 9'h000},
        {3'b110, 8'h0A, 8'h03, 1'b0, 9'h000},
        {3'b111, 8'h0A, 8'h03, 1'b1, 9'h000}
    };

    alu8b dut (
        .Clk_in     (Clk_in),
        .Rst_in     (Rst_in),
        .A_in       (A_in),
        .B_in       (B_in),
        .C_in       (C_in),
        .Opcode_in  (Opcode_in),
        .Result_out (Result_out),
        .C_out      (C_out)
    );

    initial Clk_in = 1'b0;
    always #5 Clk_in = ~Clk_in;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got {C,R}=%h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        Rst_in    = 1'b1;
        A_in      = 8'h00;
        B_in      = 8'h00;
        C_in      = 1'b0;
        Opcode_in = 3'b000;
        #2;
        check("reset_async", {C_out, Result_out}, 9'h000);
        A_in = 8'hFE; B_in = 8'h01; C_in = 1'b1;
        @(posedge Clk_in); #1;
        check("reset_hold", {C_out, Result_out}, 9'h000);
        Rst_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            Opcode_in = tab[i][28:26];
            A_in      = tab[i][25:18];
            B_in      = tab[i][17:10];
            C_in      = tab[i][9];
            @(posedge Clk_in); #1;
            check($sformatf("vec%0d", i), {C_out, Result_out}, tab[i][8:0]);
            Opcode_in = 3'b011; A_in = 8'hFF; B_in = 8'hFF; C_in = 1'b1;
            #1;
            check($sformatf("hold%0d", i), {C_out, Result_out}, tab[i][8:0]);
        end
        // Mid-operation reset: pending ADD result is discarded until after deassert.
        Opcode_in = 3'b000; A_in = 8'hFE; B_in = 8'h01; C_in = 1'b1;
        @(posedge Clk_in); #1;
        check("pre_reset", {C_out, Result_out}, 9'h100);
        #2 Rst_in = 1'b1;
        #1;
        check("mid_reset_async", {C_out, Result_out}, 9'h000);
        @(posedge Clk_in); #1;
        check("mid_reset_edge", {C_out, Result_out}, 9'h000);
        #3 Rst_in = 1'b0;
        #1;
        check("post_deassert", {C_out, Result_out}, 9'h000);
        @(posedge Clk_in); #1;
        check("first_after_reset", {C_out, Result_out}, 9'h100);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu8b.md
ALU8B -- requirements
Module: alu8b

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits.
REQ-002 Clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_in  input  1  reset, asynchronous and active-high.
REQ-004 A_in  input  8  operand A, unsigned.
REQ-005 B_in  input  8  operand B, unsigned.
REQ-006 C_in  input  1  carry-in; used by ADD only.
REQ-007 Opcode_in  input  3  operation select.
REQ-008 Result_out  output  8  registered result.
REQ-009 C_out  output  1  registered carry/borrow/error flag.
REQ-010 One clock domain; reset is asynchronous and active-high.

Function
REQ-011 Inputs sampled every rising Clk_in edge; Result_out/C_out SHALL update on that edge, latency exactly 1 cycle, no handshake, new operation accepted every cycle.
REQ-012 Opcode 000 ADD: {C_out,Result_out} = A_in + B_in + C_in, 9-bit sum; C_out = bit 8.
REQ-013 Opcode 001 SUB: Result_out = (A_in - B_in) mod 256; C_in ignored; C_out = 1 iff A_in < B_in (borrow), else 0.
REQ-014 Opcode 010 AND: Result_out = A_in & B_in; C_out = 0.
REQ-015 Opcode 011 OR: Result_out = A_in | B_in; C_out = 0.
REQ-016 Opcode 100 MOD: Result_out = A_in mod B_in (unsigned remainder, 0..B_in-1); C_out = 0.
REQ-017 MOD with B_in = 0: Result_out = 8'h00, C_out = 1 (divide-by-zero flag).
REQ-018 Opcodes 101, 110, 111 (invalid): Result_out = 8'h00, C_out = 0.
REQ-019 C_in SHALL have no effect for any opcode other than 000.
REQ-020 Any X-free input combination SHALL yield X-free outputs after one edge.
REQ-021 Boundaries: ADD FF+FF+1 -> FF, C_out 1; SUB 00-01 -> FF, C_out 1; MOD A<B -> A; MOD B=1 -> 00.

Reset
REQ-022 While Rst_in = 1, Result_out = 8'h00 and C_out = 0, taking effect immediately without a clock edge.
REQ-023 Reset asserted mid-operation SHALL discard the pending result; first valid result appears one rising edge after Rst_in deasserts.

Structure
REQ-024 Shared package alu8b_pkg SHALL hold the 3-bit opcode constants/enum (OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_MOD=100) and the 8-bit data width constant.
REQ-025 Remainder logic SHALL be a separate combinational sub-module alu8b_mod (8-bit restoring remainder, outputs remainder and div-by-zero flag); all other ops and the output register live in alu8b.

Verification
REQ-026 ADD: A=AA, B=02, Cin=0, Op=000 -> next edge Result=AC, C_out=0; A=FE, B=01, Cin=1 -> Result=00, C_out=1.
REQ-027 SUB: A=FF, B=01, Cin=1, Op=001 -> Result=FE, C_out=0; A=00, B=01 -> Result=FF, C_out=1.
REQ-028 Logic: A=AA, B=55, Op=010 -> Result=00, C_out=0; Op=011 -> Result=FF, C_out=0.
REQ-029 MOD: A=0A, B=03, Op=100 -> Result=01, C_out=0; A=0A, B=00 -> Result=00, C_out=1.
REQ-030 Invalid: A=0A, B=03, Op=101/110/111 -> Result=00, C_out=0 each.
REQ-031 Reset: drive ADD FE+01+1, assert Rst_in between edges -> outputs 00/0 immediately; deassert -> correct result one edge later.
